// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {RUN, MEM_WAIT} hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one Execute-stage source operand; the younger M result beats W.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] ForwardE
);

    always_comb begin
        ForwardE = FWD_RF;
        if (RegWriteM && RdM != 5'd0 && RdM == RsE) begin
            ForwardE = FWD_M;
        end else if (RegWriteW && RdW != 5'd0 && RdW == RsE) begin
            ForwardE = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/redirect/forward control for the 5-stage core, with a data-memory
// wait-state FSM, a sticky wait timeout and bring-up performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             LoadE,
    input  logic             NeedBranchE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             PCSrcE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] PerfBranchCnt,
    output logic [CNT_W-1:0] PerfStallCnt,
    output logic             MemTimeoutErr
);

    localparam logic [16:0] TIMEOUT_V = {1'b0, 16'(MEM_TIMEOUT)};

    hz_state_t   state;
    hz_state_t   stateNext;
    logic [15:0] waitCnt;
    logic        memWait;
    logic        loadUse;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;

    fwd_sel uFwdA (
        .RsE      (Rs1E),
        .RdM      (RdM),
        .RegWriteM(RegWriteM),
        .RdW      (RdW),
        .RegWriteW(RegWriteW),
        .ForwardE (fwdA)
    );

    fwd_sel uFwdB (
        .RsE      (Rs2E),
        .RdM      (RdM),
        .RegWriteM(RegWriteM),
        .RdW      (RdW),
        .RegWriteW(RegWriteW),
        .ForwardE (fwdB)
    );

    assign loadUse = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // A wait cycle is the entry cycle or any MEM_WAIT cycle without ready;
    // the cycle where ready arrives already behaves as RUN.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        PCSrcE    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        memWait   = 1'b0;
        stateNext = state;
        case (state)
            RUN:      memWait = MemReqM && !MemReadyM;
            MEM_WAIT: memWait = !MemReadyM;
            default:  memWait = 1'b0;
        endcase
        if (reset) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
            stateNext = RUN;
        end else begin
            ForwardAE = fwdA;
            ForwardBE = fwdB;
            stateNext = memWait ? MEM_WAIT : RUN;
            if (memWait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (NeedBranchE) begin
                PCSrcE = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (loadUse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Wait counter only advances on MEM_WAIT cycles still lacking ready, and saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            PerfBranchCnt <= '0;
            PerfStallCnt  <= '0;
            waitCnt       <= '0;
            MemTimeoutErr <= 1'b0;
        end else begin
            if (PCSrcE) begin
                PerfBranchCnt <= PerfBranchCnt + CNT_W'(1);
            end
            if (StallF) begin
                PerfStallCnt <= PerfStallCnt + CNT_W'(1);
            end
            if (state == MEM_WAIT && !MemReadyM) begin
                if (waitCnt != 16'hFFFF) begin
                    waitCnt <= waitCnt + 16'd1;
                end
                if (({1'b0, waitCnt} + 17'd1) >= TIMEOUT_V) begin
                    MemTimeoutErr <= 1'b1;
                end
            end else begin
                waitCnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1D;
        logic [4:0] rs2D;
        logic [4:0] rs1E;
        logic [4:0] rs2E;
        logic [4:0] rdE;
        logic       loadE;
        logic       needBranchE;
        logic [4:0] rdM;
        logic       regWriteM;
        logic [4:0] rdW;
        logic       regWriteW;
        logic       memReqM;
        logic       memReadyM;
    } inVec_t;

    typedef struct {
        string       tag;
        logic [11:0] ctrl;
        logic [31:0] br;
        logic [31:0] st;
        logic        err;
    } expRec_t;

    // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, PCSrcE, ForwardAE, ForwardBE}
    localparam logic [11:0] C_NONE = 12'b0000_000_0_00_00;
    localparam logic [11:0] C_RST  = 12'b0000_111_0_00_00;
    localparam logic [11:0] C_LU   = 12'b1100_010_0_00_00;
    localparam logic [11:0] C_BR   = 12'b0000_110_1_00_00;
    localparam logic [11:0] C_MW   = 12'b1111_001_0_00_00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic        LoadE = 1'b0, NeedBranchE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic        MemReqM = 1'b0, MemReadyM = 1'b0;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, PCSrcE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] PerfBranchCnt, PerfStallCnt;
    logic        MemTimeoutErr;

    expRec_t sb[$];
    int      testsRun = 0;
    int      testsFailed = 0;
    inVec_t  v;

    hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .LoadE(LoadE), .NeedBranchE(NeedBranchE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .PCSrcE(PCSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .PerfBranchCnt(PerfBranchCnt), .PerfStallCnt(PerfStallCnt),
        .MemTimeoutErr(MemTimeoutErr)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input inVec_t iv, input string tag, input logic [11:0] ctrl,
                                 input int br, input int st, input logic err);
        expRec_t e;
        @(posedge clk);
        #1;
        reset       = iv.rst;
        Rs1D        = iv.rs1D;
        Rs2D        = iv.rs2D;
        Rs1E        = iv.rs1E;
        Rs2E        = iv.rs2E;
        RdE         = iv.rdE;
        LoadE       = iv.loadE;
        NeedBranchE = iv.needBranchE;
        RdM         = iv.rdM;
        RegWriteM   = iv.regWriteM;
        RdW         = iv.rdW;
        RegWriteW   = iv.regWriteW;
        MemReqM     = iv.memReqM;
        MemReadyM   = iv.memReadyM;
        e.tag  = tag;
        e.ctrl = ctrl;
        e.br   = 32'(br);
        e.st   = 32'(st);
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input expRec_t e);
        logic [11:0] act;
        act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, PCSrcE, ForwardAE, ForwardBE};
        testsRun++;
        if (act !== e.ctrl) begin
            testsFailed++;
            $display("[TB] FAIL %s ctrl: got %b expected %b", e.tag, act, e.ctrl);
        end
        testsRun++;
        if (PerfBranchCnt !== e.br) begin
            testsFailed++;
            $display("[TB] FAIL %s PerfBranchCnt: got %0d expected %0d", e.tag, PerfBranchCnt, e.br);
        end
        testsRun++;
        if (PerfStallCnt !== e.st) begin
            testsFailed++;
            $display("[TB] FAIL %s PerfStallCnt: got %0d expected %0d", e.tag, PerfStallCnt, e.st);
        end
        testsRun++;
        if (MemTimeoutErr !== e.err) begin
            testsFailed++;
            $display("[TB] FAIL %s MemTimeoutErr: got %b expected %b", e.tag, MemTimeoutErr, e.err);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            checkOutput(sb.pop_front());
        end
    end

    initial begin
        // Reset overrides forwarding, branch and memory wait
        v = '0; v.rst = 1; v.rs1E = 5; v.rdM = 5; v.regWriteM = 1; v.needBranchE = 1; v.loadE = 1; v.rdE = 7; v.rs1D = 7;
        applyStimulus(v, "rstHold", C_RST, 0, 0, 0);
        v = '0; v.rst = 1; v.memReqM = 1;
        applyStimulus(v, "rstMem", C_RST, 0, 0, 0);

        v = '0; v.rs1E = 5; v.rdM = 5; v.regWriteM = 1; v.rdW = 5; v.regWriteW = 1;
        applyStimulus(v, "fwdM", 12'b0000_000_0_10_00, 0, 0, 0);
        v.regWriteM = 0;
        applyStimulus(v, "fwdW", 12'b0000_000_0_01_00, 0, 0, 0);
        v.regWriteM = 1; v.rdM = 0; v.rdW = 0;
        applyStimulus(v, "fwdZero", C_NONE, 0, 0, 0);
        v = '0; v.rs1E = 3; v.rs2E = 9; v.rdM = 9; v.regWriteM = 1; v.rdW = 3; v.regWriteW = 1;
        applyStimulus(v, "fwdBoth", 12'b0000_000_0_01_10, 0, 0, 0);

        v = '0; v.loadE = 1; v.rdE = 7; v.rs2D = 7;
        applyStimulus(v, "loadUse", C_LU, 0, 0, 0);
        v = '0;
        applyStimulus(v, "loadUseDone", C_NONE, 0, 1, 0);
        v = '0; v.loadE = 1;
        applyStimulus(v, "loadUseRd0", C_NONE, 0, 1, 0);

        v = '0; v.loadE = 1; v.rdE = 7; v.rs1D = 7; v.needBranchE = 1;
        applyStimulus(v, "brVsLu", C_BR, 0, 1, 0);
        v = '0;
        applyStimulus(v, "brDone", C_NONE, 1, 1, 0);

        // Memory wait with a branch held in E the whole time
        v = '0; v.memReqM = 1; v.needBranchE = 1;
        applyStimulus(v, "mwEntry", C_MW, 1, 1, 0);
        applyStimulus(v, "mwWait1", C_MW, 1, 2, 0);
        applyStimulus(v, "mwWait2", C_MW, 1, 3, 0);
        v.memReadyM = 1;
        applyStimulus(v, "mwReadyBr", C_BR, 1, 4, 0);
        v = '0;
        applyStimulus(v, "mwDone", C_NONE, 2, 4, 0);

        v = '0; v.memReqM = 1; v.memReadyM = 1;
        applyStimulus(v, "memZeroWait", C_NONE, 2, 4, 0);
        v = '0; v.memReadyM = 1;
        applyStimulus(v, "readyNoReq", C_NONE, 2, 4, 0);

        v = '0; v.memReqM = 1; v.loadE = 1; v.rdE = 7; v.rs1D = 7;
        applyStimulus(v, "memVsLu", C_MW, 2, 4, 0);
        v.memReadyM = 1;
        applyStimulus(v, "luAfterWait", C_LU, 2, 5, 0);
        v = '0;
        applyStimulus(v, "luAfterDone", C_NONE, 2, 6, 0);

        // Timeout at 4 MEM_WAIT cycles, sticky past ready
        v = '0; v.memReqM = 1;
        applyStimulus(v, "toEntry", C_MW, 2, 6, 0);
        applyStimulus(v, "toWait1", C_MW, 2, 7, 0);
        applyStimulus(v, "toWait2", C_MW, 2, 8, 0);
        applyStimulus(v, "toWait3", C_MW, 2, 9, 0);
        applyStimulus(v, "toWait4", C_MW, 2, 10, 0);
        applyStimulus(v, "toErrSet", C_MW, 2, 11, 1);
        v.memReadyM = 1;
        applyStimulus(v, "toReady", C_NONE, 2, 12, 1);
        v = '0;
        applyStimulus(v, "toSticky", C_NONE, 2, 12, 1);

        // Reset asserted mid-wait
        v = '0; v.memReqM = 1;
        applyStimulus(v, "rmEntry", C_MW, 2, 12, 1);
        applyStimulus(v, "rmWait", C_MW, 2, 13, 1);
        v.rst = 1; v.needBranchE = 1;
        applyStimulus(v, "rmResetOn", C_RST, 2, 14, 1);
        applyStimulus(v, "rmResetHeld", C_RST, 0, 0, 0);
        v = '0; v.needBranchE = 1;
        applyStimulus(v, "rmRunBr", C_BR, 0, 0, 0);
        v = '0;
        applyStimulus(v, "rmBrCnt", C_NONE, 1, 0, 0);

        for (int i = 0; i < 4 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and redirect controller for the 5-stage RISC-V core. It consumes the branch decision `NeedBranchE` from the branch unit, register-address and write-enable information from the D/E/M/W stages, and a data-memory ready handshake. It drives the stall, flush, forwarding and PC-select controls for the datapath. A small FSM sequences data-memory wait states, and performance counters and a sticky timeout flag support bring-up.

## Interface
Parameters:
- `CNT_W`, 32: width of the performance counters.
- `MEM_TIMEOUT`, 255: cycles spent in MEM_WAIT before `MemTimeoutErr` sets. Legal range is 1..2^16-1.

Ports:
- `clk`: in, 1, the single clock.
- `reset`: in, 1, synchronous, active-high.
- `Rs1D`, `Rs2D`: in, 5 each, source registers in Decode.
- `Rs1E`, `Rs2E`, `RdE`: in, 5 each, source and destination registers in Execute.
- `LoadE`: in, 1, the Execute instruction is a load (`ResultSrcE[0]`).
- `NeedBranchE`: in, 1, taken branch or jump resolved in Execute.
- `RdM`, `RegWriteM`: in, 5 / 1, Memory-stage destination and write enable.
- `RdW`, `RegWriteW`: in, 5 / 1, Writeback-stage destination and write enable.
- `MemReqM`: in, 1, the Memory-stage instruction accesses data memory.
- `MemReadyM`: in, 1, data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM`: out, 1 each, hold the corresponding pipeline register.
- `FlushD`, `FlushE`, `FlushW`: out, 1 each, insert a bubble into the corresponding register.
- `PCSrcE`: out, 1, select the branch target for the next PC.
- `ForwardAE`, `ForwardBE`: out, 2 each. Encoding: 00 regfile, 01 from W, 10 from M.
- `PerfBranchCnt`, `PerfStallCnt`: out, `CNT_W` each.
- `MemTimeoutErr`: out, 1, sticky.

## Operation
- FSM states are RUN and MEM_WAIT. Reset puts the FSM in RUN.
- RUN → MEM_WAIT when `MemReqM && !MemReadyM`. MEM_WAIT → RUN on the first cycle with `MemReadyM=1`.
- **MEM_WAIT outputs (including the cycle of entry):**
  - `StallF`, `StallD`, `StallE` and `StallM` are 1.
  - `FlushW` is 1.
  - `PCSrcE` is forced to 0. E is frozen, so `NeedBranchE` persists and is honoured in RUN.
  - No other flush is asserted.
- **Branch in RUN** (`NeedBranchE=1`): `PCSrcE`, `FlushD` and `FlushE` are 1. This has priority over load-use, so no stall is asserted that cycle.
- **Load-use in RUN:** the condition is `LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D)`. It asserts `StallF`, `StallD` and `FlushE` for exactly one cycle, because the load has moved to M on the next cycle.
- **Forwarding** is combinational and independent of state.
  - `ForwardAE=10` if `RegWriteM && RdM!=0 && RdM==Rs1E`.
  - Otherwise `ForwardAE=01` if `RegWriteW && RdW!=0 && RdW==Rs1E`.
  - Otherwise `ForwardAE=00`. `ForwardBE` uses the same rules with `Rs2E`.
- **Wait counter:** it counts cycles in MEM_WAIT and clears on entering RUN. When it reaches `MEM_TIMEOUT`, `MemTimeoutErr` sets and stays set until `reset`. The counter saturates and does not wrap.
- **`PerfBranchCnt`** increments on each cycle `PCSrcE=1`.
- **`PerfStallCnt`** increments on each cycle `StallF=1`.
- Both performance counters wrap modulo 2^`CNT_W`.

## Timing
- Stall, flush, `PCSrcE` and forward outputs are combinational from the inputs and the registered state. Zero latency.
- **While `reset=1`:**
  - `FlushD`, `FlushE` and `FlushW` are 1.
  - All stalls, `PCSrcE` and both forwards are 0.
  - On the clock edge, the counters, the wait counter and `MemTimeoutErr` are set to 0 and the state to RUN.
- Reset asserted during MEM_WAIT abandons the wait on the next edge.
- `MemReqM && MemReadyM` in the same cycle completes in zero cycles: no MEM_WAIT entry and no stall.
- `MemReadyM` is ignored when `MemReqM=0` in RUN.
- Load-use and memory-wait in the same cycle: MEM_WAIT outputs win. After the wait, load-use is re-evaluated.
- Branch and memory-wait in the same cycle: MEM_WAIT wins and the branch is deferred.

## Structure
- Package `hazard_pkg` holds:
  - `typedef enum logic {RUN, MEM_WAIT} hz_state_t`.
  - `localparam` constants `FWD_RF=2'b00`, `FWD_W=2'b01`, `FWD_M=2'b10`.
- One sub-module, `fwd_sel`, is instantiated twice, for operands A and B. Inputs: `RsE`, `RdM`, `RegWriteM`, `RdW`, `RegWriteW`. Output: the 2-bit forward select.
- The FSM, wait counter and performance counters stay in the top module.

## Test plan
- **Forwarding:** `Rs1E=5`, `RdM=5`, `RegWriteM=1`, `RdW=5`, `RegWriteW=1` → `ForwardAE=10`. With `RegWriteM=0` → `01`. With `RdM=RdW=0` → `00`.
- **Load-use:** `LoadE=1`, `RdE=7`, `Rs2D=7` → one cycle of `StallF=StallD=FlushE=1`. `PerfStallCnt` becomes 1. With `RdE=0` → no stall.
- **Branch vs load-use:** `NeedBranchE=1` together with the load-use condition → `PCSrcE=FlushD=FlushE=1` and `StallF=0`. `PerfBranchCnt` becomes 1.
- **Memory wait with deferred branch:**
  - Stimulus: `MemReqM=1`, `MemReadyM=0` for 3 cycles, then 1, with `NeedBranchE=1` throughout.
  - Response: all four stalls and `FlushW` are 1 and `PCSrcE=0` for 3 cycles. On the 4th cycle the FSM is in RUN and `PCSrcE=1`. `PerfStallCnt` is 3.
- **Timeout:** with `MEM_TIMEOUT=4`, hold `MemReadyM=0` → `MemTimeoutErr` rises after 4 MEM_WAIT cycles and stays 1 after `MemReadyM=1`. Only `reset` clears it.
- **Reset mid-wait:** assert `reset` in MEM_WAIT → next cycle the FSM is in RUN, counters are 0 and `FlushD=FlushE=FlushW=1` while `reset` is held.
